// File: rtl/regfile_pkg.sv
// Shared Y86 register-file definitions: data widths, architectural register IDs
// and the register-ID validity helper used by the write and read paths.
package regfile_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int BYTE_W     = 8;
    localparam int NREGS_DEF  = 8;

    typedef enum logic [BYTE_W-1:0] {
        REAX  = 8'h0,
        RECX  = 8'h1,
        REDX  = 8'h2,
        REBX  = 8'h3,
        RESP  = 8'h4,
        REBP  = 8'h5,
        RESI  = 8'h6,
        REDI  = 8'h7,
        RNONE = 8'hF
    } reg_id_e;

    // RNONE is rejected explicitly so the check stays correct if NREGS grows past 15.
    function automatic logic id_ok(input logic [BYTE_W-1:0] id, input int nregs);
        return (int'(id) < nregs) && (id != RNONE);
    endfunction

endpackage

// File: rtl/regfile.sv
// Y86 register file: two synchronous write ports (E, M; M wins on conflict) and
// two combinational read ports with optional same-cycle write-through bypass.
module regfile
    import regfile_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en_i,
    input  logic [BYTE_W-1:0] dstE_i,
    input  logic [WORD_W-1:0] valE_i,
    input  logic [BYTE_W-1:0] dstM_i,
    input  logic [WORD_W-1:0] valM_i,
    input  logic [BYTE_W-1:0] srcA_i,
    input  logic [BYTE_W-1:0] srcB_i,
    output logic [WORD_W-1:0] valA_o,
    output logic [WORD_W-1:0] valB_o
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [WORD_W-1:0] r_regs [NREGS];

    logic              w_e_ok;
    logic              w_m_ok;
    logic              w_byp;
    logic [BYTE_W-1:0] w_src [2];
    logic [WORD_W-1:0] w_rd  [2];

    assign w_e_ok   = wb_en_i && id_ok(dstE_i, NREGS);
    assign w_m_ok   = wb_en_i && id_ok(dstM_i, NREGS);
    assign w_byp    = (BYPASS != 0);
    assign w_src[0] = srcA_i;
    assign w_src[1] = srcB_i;

    // NOTE: the storage array is reset explicitly because reset must clear every
    // architectural register; that keeps it in flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_e_ok) begin
                r_regs[dstE_i[IDX_W-1:0]] <= valE_i;
            end
            // Last non-blocking assignment wins: M overrides E (popl %esp rule).
            if (w_m_ok) begin
                r_regs[dstM_i[IDX_W-1:0]] <= valM_i;
            end
        end
    end

    // NOTE: combinational logic uses blocking assignments with a default first,
    // so every path assigns w_rd and no latch is inferred.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rd[p] = '0;
            if (!rst) begin
                if (id_ok(w_src[p], NREGS)) begin
                    w_rd[p] = r_regs[w_src[p][IDX_W-1:0]];
                end
                // M is checked last so it takes priority over E, matching the write path.
                if (w_byp && w_e_ok && (w_src[p] == dstE_i)) begin
                    w_rd[p] = valE_i;
                end
                if (w_byp && w_m_ok && (w_src[p] == dstM_i)) begin
                    w_rd[p] = valM_i;
                end
            end
        end
    end

    assign valA_o = w_rd[0];
    assign valB_o = w_rd[1];

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Y86 general-purpose register file. It is the write-back consumer of the execute stage's (dstE, valE) result and of the memory stage's (dstM, valM) result.
- It also supplies the decode stage with valA/valB for srcA/srcB.
- Eight 32-bit registers, two synchronous write ports (E and M), two combinational read ports with optional same-cycle write-through bypass.

Parameters:
- WORD_W, 32: data width of each register and of all val ports.
- NREGS, 8: number of architectural registers; IDs 0..NREGS-1 are valid.
- BYPASS, 1: 1 = a read of a register being written this cycle returns the write data; 0 = read returns the pre-write value.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
- wb_en_i  input  1  write-back enable; 0 = both write ports ignored (pipeline stall/bubble).
- dstE_i  input  8  E-port destination register ID (`BYTE); 0xF = RNONE.
- valE_i  input  WORD_W  E-port write data.
- dstM_i  input  8  M-port destination register ID; 0xF = RNONE.
- valM_i  input  WORD_W  M-port write data.
- srcA_i  input  8  read port A register ID; 0xF = RNONE.
- srcB_i  input  8  read port B register ID; 0xF = RNONE.
- valA_o  output  WORD_W  read port A data.
- valB_o  output  WORD_W  read port B data.

Behaviour:
- Reset:
  - On a clk edge with rst=1, all NREGS registers become 0, regardless of the write ports.
  - While rst is high, valA_o and valB_o read 0, because the bypass is also gated by rst.
  - Reset asserted mid-sequence discards any write presented in that cycle.
  - The first write is accepted on the first edge with rst=0.
- Write:
  - On a clk edge with rst=0 and wb_en_i=1, the E port writes regs[dstE_i] <= valE_i when dstE_i < NREGS.
  - Under the same conditions, the M port writes regs[dstM_i] <= valM_i when dstM_i < NREGS.
  - Write latency is 1 cycle: data is visible on the read ports from the next cycle, or in the same cycle when BYPASS=1.
- Invalid IDs: dstE/dstM equal to RNONE (0xF) or any value >= NREGS is a no-op. No other register is disturbed.
- Write conflict: dstE_i == dstM_i and both valid means the M port wins and regs get valM_i. This is the Y86 popl %esp rule.
- Read:
  - Combinational; valA_o = regs[srcA_i], valB_o = regs[srcB_i].
  - srcX_i equal to RNONE or >= NREGS returns 0.
  - srcA_i == srcB_i returns the same value on both ports.
- Bypass (BYPASS=1, rst=0, wb_en_i=1), evaluated per read port:
  - If srcX matches a valid dstM_i, the output is valM_i.
  - Otherwise, if srcX matches a valid dstE_i, the output is valE_i.
  - Otherwise, the output is the register contents.
- wb_en_i=0: no state change and no bypass, so reads return stored values.
- Arithmetic: none. Values are stored verbatim at WORD_W bits, with no sign or width conversion.
- No X propagation: every output is driven from defined state after the first reset.

Decomposition:
- Shared defines file holds: `WORD / `BYTE ranges, register IDs REAX=0, RECX=1, REDX=2, REBX=3, RESP=4, REBP=5, RESI=6, REDI=7, and RNONE=0xF.
- No sub-module: storage, write-priority and bypass fit in one block (~150 lines).

Test Plan:
- Reset/readback: rst=1 for 2 cycles, then srcA=0..7 sweep → valA_o=0x00000000 for every ID.
- Basic write (BYPASS=0): wb_en=1, dstE=REAX(0), valE=0x0000000A, dstM=RNONE; next cycle srcA=0 → valA_o=0x0000000A. In the write cycle itself, valA_o=0 (pre-write value).
- Dual write with conflict:
  - Same cycle dstE=RESP(4) valE=0x00000104, dstM=RESP valM=0x00000200 → next cycle srcB=4 gives valB_o=0x00000200.
  - Separate regs dstE=1/valE=0x11, dstM=2/valM=0x22 → both stored.
- Bypass (BYPASS=1): regs[3]=0x5; write dstE=3 valE=0x77 while srcA=3 and srcB=3 → both ports show 0x77 in the same cycle. With dstM=3 valM=0x99 also present → both show 0x99.
- Invalid/stall:
  - dstE=0xF or 0x8 with valE=0xDEADBEEF → no register changes (sweep shows prior values).
  - wb_en=0 with dstE=0 valE=0x1234 → regs[0] unchanged, no bypass.
  - srcA=0xF → valA_o=0.
- Reset mid-operation: regs[6]=0x42; assert rst in the same cycle as a write dstE=6 valE=0x99 → regs[6]=0 afterwards. Deassert rst and write 0x99 → read 0x99 next cycle.
